// File: rtl/fault_reaction_ctrl.sv
// Fault reaction controller: registers safety-monitor alarms, latches fault masks, raises an IRQ
// and escalates to a system reset request on ack timeout. Optional macro: FRC_FAULT_INJECT_EN.
module fault_reaction_ctrl #(
   parameter int unsigned ACK_TIMEOUT   = 1024,
   parameter int unsigned RST_PULSE_LEN = 16,
   parameter int unsigned CNT_W         = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sf_error_alarm_i,
   input  logic [4:0]       sf_error_code_i,
`ifdef FRC_FAULT_INJECT_EN
   input  logic [4:0]       inject_i,
`endif
   input  logic             irq_ack_i,
   output logic             irq_o,
   output logic             safe_state_o,
   output logic             sys_rst_req_o,
   output logic [4:0]       first_code_o,
   output logic [4:0]       accum_code_o,
   output logic [CNT_W-1:0] fault_cnt_o,
   output logic [1:0]       state_o
);

   // One timer serves both the ack timeout in ALERT and the pulse length in RST_REQ.
   localparam int unsigned TmrMax = (ACK_TIMEOUT > RST_PULSE_LEN) ? ACK_TIMEOUT : RST_PULSE_LEN;
   localparam int unsigned TmrW   = $clog2(TmrMax) + 1;

   typedef enum logic [1:0] {
      StIdle   = 2'b00,
      StAlert  = 2'b01,
      StSafe   = 2'b10,
      StRstReq = 2'b11
   } state_e;

   state_e            state_q, state_d;
   logic              alarm_q;
   logic [4:0]        code_q;
   logic [4:0]        act, act_prev_q;
   logic              detect, fault_evt;
   logic              alert_timeout, pulse_done;
   logic              irq_q, irq_d;
   logic              safe_q, safe_d;
   logic              rst_req_q, rst_req_d;
   logic [4:0]        first_q, first_d;
   logic [4:0]        accum_q, accum_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [TmrW-1:0]   timer_q, timer_d;

`ifdef FRC_FAULT_INJECT_EN
   logic [4:0] inject_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         inject_q <= 5'h00;
      end else begin
         inject_q <= inject_i;
      end
   end

   assign act = ~code_q | inject_q;
`else
   assign act = ~code_q;
`endif

   assign detect        = ~alarm_q | (|act);
   // An event is a newly alarming mechanism, counted once per cycle regardless of bit count.
   assign fault_evt     = |(act & ~act_prev_q);
   assign alert_timeout = (timer_q == TmrW'(ACK_TIMEOUT - 1));
   assign pulse_done    = (timer_q == TmrW'(RST_PULSE_LEN - 1));

   // State register and datapath registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         alarm_q    <= 1'b1;
         code_q     <= 5'h1F;
         act_prev_q <= 5'h00;
         state_q    <= StIdle;
         irq_q      <= 1'b0;
         safe_q     <= 1'b0;
         rst_req_q  <= 1'b0;
         first_q    <= 5'h00;
         accum_q    <= 5'h00;
         cnt_q      <= '0;
         timer_q    <= '0;
      end else begin
         alarm_q    <= sf_error_alarm_i;
         code_q     <= sf_error_code_i;
         act_prev_q <= act;
         state_q    <= state_d;
         irq_q      <= irq_d;
         safe_q     <= safe_d;
         rst_req_q  <= rst_req_d;
         first_q    <= first_d;
         accum_q    <= accum_d;
         cnt_q      <= cnt_d;
         timer_q    <= timer_d;
      end
   end

   // Next-state logic; ack takes priority over a coincident timeout.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (detect) state_d = StAlert;
         end
         StAlert: begin
            if (irq_ack_i)          state_d = StSafe;
            else if (alert_timeout) state_d = StRstReq;
         end
         StSafe:   state_d = StSafe;
         StRstReq: state_d = StRstReq;
         default:  state_d = StIdle;
      endcase
   end

   // Output and timer next values
   always_comb begin
      irq_d     = irq_q;
      safe_d    = safe_q;
      rst_req_d = rst_req_q;
      first_d   = first_q;
      timer_d   = timer_q;
      accum_d   = accum_q | act;
      cnt_d     = cnt_q;
      if (fault_evt && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);

      unique case (state_q)
         StIdle: begin
            if (detect) begin
               irq_d   = 1'b1;
               first_d = act;
               timer_d = '0;
            end
         end
         StAlert: begin
            if (irq_ack_i) begin
               irq_d  = 1'b0;
               safe_d = 1'b1;
            end else if (alert_timeout) begin
               irq_d     = 1'b0;
               rst_req_d = 1'b1;
               timer_d   = '0;
            end else begin
               timer_d = timer_q + TmrW'(1);
            end
         end
         StRstReq: begin
            if (rst_req_q) begin
               if (pulse_done) rst_req_d = 1'b0;
               else            timer_d   = timer_q + TmrW'(1);
            end
         end
         default: ;
      endcase
   end

   assign irq_o         = irq_q;
   assign safe_state_o  = safe_q;
   assign sys_rst_req_o = rst_req_q;
   assign first_code_o  = first_q;
   assign accum_code_o  = accum_q;
   assign fault_cnt_o   = cnt_q;
   assign state_o       = state_q;

endmodule
